// File: rtl/sipo_frame_pkg.sv
// rtl/sipo_frame_pkg.sv - shared FSM encoding and framing constants for sipo_frame_rx
package sipo_frame_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/sipo_shift.sv
// rtl/sipo_shift.sv - WIDTH-bit serial-in parallel-out register, MSB arrives first
module sipo_shift #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             shift_en,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], sin};
    end
  end

endmodule

// File: rtl/sipo_frame_rx.sv
// rtl/sipo_frame_rx.sv - strobed serial frame receiver: start, WIDTH data bits MSB first, parity, stop
module sipo_frame_rx
  import sipo_frame_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic             CK,
  input  logic             RN,
  input  logic             SI,
  input  logic             EN,
  output logic [WIDTH-1:0] Dout,
  output logic             VALID,
  output logic             PERR,
  output logic             FERR,
  output logic             BUSY
);

  localparam int CW = $clog2(WIDTH + 1);

  rx_state_e        state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             par, par_n;
  logic             perr_lat, perr_lat_n;
  logic             shift_en;
  logic             load;
  logic             valid_n, perr_n, ferr_n;
  logic [WIDTH-1:0] shreg;

  sipo_shift #(.WIDTH(WIDTH)) u_shift (
    .clk      (CK),
    .clr_n    (RN),
    .shift_en (shift_en),
    .sin      (SI),
    .q        (shreg)
  );

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    par_n      = par;
    perr_lat_n = perr_lat;
    shift_en   = 1'b0;
    load       = 1'b0;
    valid_n    = 1'b0;
    perr_n     = 1'b0;
    ferr_n     = 1'b0;
    if (EN) begin
      unique case (state)
        IDLE: begin
          if (SI == START_BIT) begin
            state_n = DATA;
            cnt_n   = '0;
            par_n   = 1'b0;
          end
        end
        DATA: begin
          shift_en = 1'b1;
          par_n    = par ^ SI;
          cnt_n    = cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) state_n = PARITY;
        end
        PARITY: begin
          // Odd parity expects the complement of the running data XOR.
          perr_lat_n = SI != (par ^ (PARITY_ODD != 0));
          state_n    = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (SI == STOP_BIT) begin
            if (perr_lat) begin
              perr_n = 1'b1;
            end else begin
              valid_n = 1'b1;
              load    = 1'b1;
            end
          end else begin
            ferr_n = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state    <= IDLE;
      cnt      <= '0;
      par      <= 1'b0;
      perr_lat <= 1'b0;
      Dout     <= '0;
      VALID    <= 1'b0;
      PERR     <= 1'b0;
      FERR     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      par      <= par_n;
      perr_lat <= perr_lat_n;
      VALID    <= valid_n;
      PERR     <= perr_n;
      FERR     <= ferr_n;
      if (load) Dout <= shreg;
    end
  end

  assign BUSY = (state != IDLE);

endmodule

// File: tb/tb_sipo_frame_rx.sv
// tb/tb_sipo_frame_rx.sv - directed scenario bench for sipo_frame_rx
module tb_sipo_frame_rx;

  logic       CK = 1'b0;
  logic       RN = 1'b0;
  logic       SI = 1'b1;
  logic       EN = 1'b0;
  logic [3:0] Dout;
  logic       VALID, PERR, FERR, BUSY;

  int n_checks = 0;
  int n_pass   = 0;
  int n_valid  = 0;
  int n_perr   = 0;
  int n_ferr   = 0;
  logic [3:0] got [0:3];

  sipo_frame_rx #(.WIDTH(4), .PARITY_ODD(0)) dut (
    .CK    (CK),
    .RN    (RN),
    .SI    (SI),
    .EN    (EN),
    .Dout  (Dout),
    .VALID (VALID),
    .PERR  (PERR),
    .FERR  (FERR),
    .BUSY  (BUSY)
  );

  always #5 CK = ~CK;

  // Pulse monitor on the falling edge: a pulse longer than one cycle is counted twice.
  always @(negedge CK) begin
    if (VALID) begin
      if (n_valid < 4) got[n_valid] = Dout;
      n_valid++;
    end
    if (PERR) n_perr++;
    if (FERR) n_ferr++;
  end

  task automatic clr_mon();
    n_valid = 0;
    n_perr  = 0;
    n_ferr  = 0;
  endtask

  task automatic send_bit(input logic b, input int gap);
    @(negedge CK);
    SI = b;
    EN = 1'b1;
    repeat (gap) begin
      @(negedge CK);
      EN = 1'b0;
      SI = ~b;
    end
  endtask

  task automatic send_frame(input logic [15:0] bits, input int n, input int gap);
    for (int i = n - 1; i >= 0; i--) send_bit(bits[i], gap);
    @(negedge CK);
    EN = 1'b0;
    SI = 1'b1;
    repeat (2) @(negedge CK);
  endtask

  task automatic test_reset();
    RN = 1'b0;
    SI = 1'b1;
    EN = 1'b1;
    repeat (3) @(negedge CK);
    n_checks++; if (Dout !== 4'h0) $display("FAIL reset_dout: got %h expected 0", Dout); else n_pass++;
    n_checks++; if ({VALID, PERR, FERR, BUSY} !== 4'b0000) $display("FAIL reset_flags: got %b expected 0000", {VALID, PERR, FERR, BUSY}); else n_pass++;
    RN = 1'b1;
    clr_mon();
    repeat (3) @(negedge CK);
    n_checks++; if (BUSY !== 1'b0) $display("FAIL idle_high_busy: got %b expected 0", BUSY); else n_pass++;
    EN = 1'b0;
  endtask

  task automatic test_good_frame();
    clr_mon();
    send_frame(16'b0101001, 7, 0);
    n_checks++; if (n_valid !== 1) $display("FAIL s1_valid_count: got %0d expected 1", n_valid); else n_pass++;
    n_checks++; if (Dout !== 4'b1010) $display("FAIL s1_dout: got %b expected 1010", Dout); else n_pass++;
    n_checks++; if (n_perr + n_ferr !== 0) $display("FAIL s1_errors: got %0d expected 0", n_perr + n_ferr); else n_pass++;
  endtask

  task automatic test_parity_error();
    clr_mon();
    send_frame(16'b0111001, 7, 0);
    n_checks++; if (n_perr !== 1) $display("FAIL s2_perr_count: got %0d expected 1", n_perr); else n_pass++;
    n_checks++; if (n_valid !== 0) $display("FAIL s2_valid_count: got %0d expected 0", n_valid); else n_pass++;
    n_checks++; if (Dout !== 4'b1010) $display("FAIL s2_dout_held: got %b expected 1010", Dout); else n_pass++;
  endtask

  task automatic test_framing_error();
    clr_mon();
    send_frame(16'b0001100, 7, 0);
    n_checks++; if (n_ferr !== 1) $display("FAIL s3_ferr_count: got %0d expected 1", n_ferr); else n_pass++;
    n_checks++; if (n_perr + n_valid !== 0) $display("FAIL s3_other_pulses: got %0d expected 0", n_perr + n_valid); else n_pass++;
    n_checks++; if (Dout !== 4'b1010) $display("FAIL s3_dout_held: got %b expected 1010", Dout); else n_pass++;
    n_checks++; if (BUSY !== 1'b0) $display("FAIL s3_back_idle: got %b expected 0", BUSY); else n_pass++;
  endtask

  task automatic test_sparse_enable();
    logic [6:0] bits;
    int busy_bad;
    bits = 7'b0011001;
    busy_bad = 0;
    clr_mon();
    for (int i = 6; i >= 0; i--) begin
      @(negedge CK);
      SI = bits[i];
      EN = 1'b1;
      repeat (2) begin
        @(negedge CK);
        EN = 1'b0;
        SI = ~SI;
        if (BUSY !== (i != 0)) busy_bad++;
      end
    end
    repeat (3) @(negedge CK);
    n_checks++; if (busy_bad !== 0) $display("FAIL s4_busy_span: got %0d bad cycles expected 0", busy_bad); else n_pass++;
    n_checks++; if (n_valid !== 1) $display("FAIL s4_valid_one_cycle: got %0d expected 1", n_valid); else n_pass++;
    n_checks++; if (Dout !== 4'b0110) $display("FAIL s4_dout: got %b expected 0110", Dout); else n_pass++;
  endtask

  task automatic test_mid_reset();
    clr_mon();
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    @(negedge CK);
    EN = 1'b0;
    n_checks++; if (BUSY !== 1'b1) $display("FAIL s5_busy_before: got %b expected 1", BUSY); else n_pass++;
    RN = 1'b0;
    #1;
    n_checks++; if (Dout !== 4'h0) $display("FAIL s5_dout_cleared: got %b expected 0000", Dout); else n_pass++;
    n_checks++; if ({VALID, PERR, FERR, BUSY} !== 4'b0000) $display("FAIL s5_flags_cleared: got %b expected 0000", {VALID, PERR, FERR, BUSY}); else n_pass++;
    @(negedge CK);
    RN = 1'b1;
    send_frame(16'b0111101, 7, 0);
    n_checks++; if (n_valid !== 1 || n_perr !== 0 || n_ferr !== 0) $display("FAIL s5_pulses: got v%0d p%0d f%0d expected v1 p0 f0", n_valid, n_perr, n_ferr); else n_pass++;
    n_checks++; if (Dout !== 4'b1111) $display("FAIL s5_dout: got %b expected 1111", Dout); else n_pass++;
  endtask

  task automatic test_back_to_back();
    clr_mon();
    send_frame(16'b00011010110001, 14, 0);
    n_checks++; if (n_valid !== 2) $display("FAIL s6_valid_count: got %0d expected 2", n_valid); else n_pass++;
    if (n_valid >= 2) begin
      n_checks++; if (got[0] !== 4'b0011) $display("FAIL s6_first: got %b expected 0011", got[0]); else n_pass++;
      n_checks++; if (got[1] !== 4'b1100) $display("FAIL s6_second: got %b expected 1100", got[1]); else n_pass++;
    end
    n_checks++; if (n_perr + n_ferr !== 0) $display("FAIL s6_errors: got %0d expected 0", n_perr + n_ferr); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_parity_error();
    test_framing_error();
    test_sparse_enable();
    test_mid_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
